cache_refill_ctrl: RTL and testbench

Miss-handling sequencer for the 2-way, 128-set, 32-byte-line cache. It sits between the tag array and the AXI bridge. On a tag miss it writes back the victim line when required, fetches the new line as an 8-beat burst and streams the beats into the data banks. It then pulses `refresh` so the tag array installs the new tag and flips LRU. Uncached accesses become a single-beat read whose word is handed back directly.

---
 rtl/cache_refill_ctrl_pkg.sv | 25 ++
 rtl/cache_refill_ctrl_line_buffer.sv | 22 ++
 rtl/cache_refill_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
// Shared constants for the refill sequencer: geometry, state encodings and
// the way-select decode used by the data-bank write port.
package cache_refill_ctrl_pkg;

  localparam int LINE_WORDS  = 8;
  localparam int WIDX_W      = $clog2(LINE_WORDS);
  localparam int INDEX_WIDTH = 7;
  localparam int TAG_WIDTH   = 32 - INDEX_WIDTH - 5;
  localparam int HIT_WIDTH   = 2;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_VIC_RD  = 4'd1;
  localparam logic [3:0] S_WB_REQ  = 4'd2;
  localparam logic [3:0] S_WB_DATA = 4'd3;
  localparam logic [3:0] S_WB_RESP = 4'd4;
  localparam logic [3:0] S_RD_REQ  = 4'd5;
  localparam logic [3:0] S_RD_DATA = 4'd6;
  localparam logic [3:0] S_REFRESH = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  function automatic logic [HIT_WIDTH-1:0] way_onehot(input logic way);
    return way ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_line_buffer.sv
// 8x32 holding buffer for the victim line: one write port, combinational read.
module line_buffer
  import cache_refill_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [WIDX_W-1:0] widx,
  input  logic [31:0]       wdata,
  input  logic [WIDX_W-1:0] ridx,
  output logic [31:0]       rdata
);

  logic [LINE_WORDS-1:0][31:0] mem;

  // Capture one victim word per write strobe
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss sequencer: optional victim write-back, 8-beat line refill into the
// data banks, tag install pulse; uncached accesses fetch a single word.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        miss,
  input  logic        write_back,
  input  logic        cached,
  input  logic [31:0] axi_raddr,
  input  logic [31:0] axi_waddr,
  input  logic        lru,
  output logic        refresh,
  output logic        busy,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  output logic [3:0]  rd_len,
  input  logic        rd_ack,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  input  logic        rd_last,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  input  logic        wr_ack,
  output logic        wr_valid,
  output logic [31:0] wr_data,
  output logic        wr_last,
  input  logic        wr_ready,
  input  logic        wr_done,
  output logic [2:0]  vic_idx,
  output logic        vic_way,
  input  logic [31:0] vic_rdata,
  output logic [1:0]  fill_we,
  output logic [2:0]  fill_idx,
  output logic [31:0] fill_data,
  output logic        uc_valid,
  output logic [31:0] uc_rdata
);

  logic [3:0]        state;
  logic [31:0]       raddr_q, waddr_q;
  logic              way_q, cached_q, kill;
  logic [3:0]        vcnt;   // 0..8: issue idx 0..7, last cycle only captures
  logic [WIDX_W-1:0] beat;   // beat index for both write-back and refill
  logic              lb_we;
  logic [WIDX_W-1:0] lb_widx;
  logic [31:0]       lb_rdata;
  logic              rd_beat;

  // vic_rdata lags vic_idx by one cycle, so the capture index trails by one
  assign lb_we   = (state == S_VIC_RD) && (vcnt != 4'd0);
  assign lb_widx = vcnt[2:0] - 3'd1;
  assign rd_beat = (state == S_RD_DATA) && rd_valid && cached_q;

  line_buffer u_lb (
    .clk   (clk),
    .we    (lb_we),
    .widx  (lb_widx),
    .wdata (vic_rdata),
    .ridx  (beat),
    .rdata (lb_rdata)
  );

  // Sequencer state, latched miss context, counters and the uncached result
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      raddr_q  <= '0;
      waddr_q  <= '0;
      way_q    <= 1'b0;
      cached_q <= 1'b0;
      vcnt     <= '0;
      beat     <= '0;
      uc_valid <= 1'b0;
      uc_rdata <= '0;
    end else begin
      uc_valid <= 1'b0;
      case (state)
        S_IDLE: if (miss && !flush) begin
          raddr_q  <= axi_raddr;
          waddr_q  <= axi_waddr;
          way_q    <= lru;
          cached_q <= cached;
          vcnt     <= '0;
          beat     <= '0;
          state    <= write_back ? S_VIC_RD : S_RD_REQ;
        end
        S_VIC_RD: begin
          vcnt <= vcnt + 4'd1;
          if (vcnt == 4'd8) begin
            vcnt  <= '0;
            state <= S_WB_REQ;
          end
        end
        S_WB_REQ: if (wr_ack) begin
          beat  <= '0;
          state <= S_WB_DATA;
        end
        S_WB_DATA: if (wr_ready) begin
          if (beat == 3'd7) begin
            beat  <= '0;
            state <= S_WB_RESP;
          end else begin
            beat <= beat + 3'd1;
          end
        end
        S_WB_RESP: if (wr_done) state <= S_RD_REQ;
        S_RD_REQ: if (rd_ack) begin
          beat  <= '0;
          state <= S_RD_DATA;
        end
        S_RD_DATA: if (rd_valid) begin
          if (!cached_q) begin
            // a flush landing on the beat itself still kills the result
            uc_rdata <= rd_data;
            uc_valid <= !(kill || flush);
            state    <= S_DONE;
          end else if (rd_last) begin
            beat  <= '0;
            state <= S_REFRESH;
          end else if (beat != 3'd7) begin
            // hold at 7 on an overlong burst rather than wrap onto word 0
            beat <= beat + 3'd1;
          end
        end
        S_REFRESH: state <= S_DONE;
        S_DONE:    state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Kill flag: any flush while busy suppresses only the uncached hand-back
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) kill <= 1'b0;
    else if (flush)             kill <= 1'b1;
  end

  // Bus, bank and status outputs decoded from state; zero outside their phase
  always_comb begin
    busy      = (state != S_IDLE);
    refresh   = (state == S_REFRESH);
    rd_req    = (state == S_RD_REQ);
    rd_addr   = rd_req ? raddr_q : '0;
    rd_len    = (rd_req && cached_q) ? 4'd7 : 4'd0;
    wr_req    = (state == S_WB_REQ);
    wr_addr   = wr_req ? waddr_q : '0;
    wr_valid  = (state == S_WB_DATA);
    wr_data   = wr_valid ? lb_rdata : '0;
    wr_last   = wr_valid && (beat == 3'd7);
    vic_idx   = '0;
    vic_way   = 1'b0;
    if (state == S_VIC_RD) begin
      vic_way = way_q;
      if (vcnt < 4'd8) vic_idx = vcnt[2:0];
    end
    fill_we   = rd_beat ? way_onehot(way_q) : '0;
    fill_idx  = rd_beat ? beat : '0;
    fill_data = rd_beat ? rd_data : '0;
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench: a scripted AXI bridge / data-bank model drives the refill
// controller; cycle numbers and data words below are worked out by hand.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 0, miss = 0, write_back = 0, cached = 0, lru = 0;
  logic [31:0] axi_raddr = '0, axi_waddr = '0;
  logic        refresh, busy, rd_req, wr_req, wr_valid, wr_last, vic_way, uc_valid;
  logic [31:0] rd_addr, wr_addr, wr_data, fill_data, uc_rdata;
  logic [3:0]  rd_len;
  logic [2:0]  vic_idx, fill_idx;
  logic [1:0]  fill_we;
  logic        rd_ack = 0, rd_valid = 0, rd_last = 0, wr_ack = 0, wr_ready = 0, wr_done = 0;
  logic [31:0] rd_data = '0, vic_rdata = '0;

  int checks = 0, errors = 0;
  int first_rd, first_wr, n_fill, n_ref, ref_cyc, idle_cyc, n_uc, n_wbeat, done_cyc;
  logic [31:0] rd_addr_s, wr_addr_s, uc_s;
  logic [3:0]  rd_len_s;

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .miss(miss), .write_back(write_back),
    .cached(cached), .axi_raddr(axi_raddr), .axi_waddr(axi_waddr), .lru(lru),
    .refresh(refresh), .busy(busy), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready), .wr_done(wr_done),
    .vic_idx(vic_idx), .vic_way(vic_way), .vic_rdata(vic_rdata), .fill_we(fill_we),
    .fill_idx(fill_idx), .fill_data(fill_data), .uc_valid(uc_valid), .uc_rdata(uc_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_or();
    return rd_addr | wr_addr | wr_data | fill_data | uc_rdata |
           {11'd0, rd_req, rd_len, wr_req, wr_valid, wr_last, refresh, busy,
            fill_we, fill_idx, uc_valid, vic_idx, vic_way};
  endfunction

  task automatic bus_idle();
    miss = 0; flush = 0; rst = 0; rd_ack = 0; rd_valid = 0; rd_last = 0; rd_data = '0;
    wr_ack = 0; wr_ready = 0; wr_done = 0; vic_rdata = '0;
  endtask

  // One miss from cycle 0 (miss sampled) until IDLE, reset, or the cycle budget.
  task automatic run(input logic [31:0] ra, input logic [31:0] wa, input logic lru_i,
                     input logic cached_i, input logic wb_i, input bit tog_rdy,
                     input int rd_gap, input int flush_at, input int rst_at);
    bit rd_on = 0, nx_rd_ack = 0, nx_wr_ack = 0, nx_wr_done = 0, held_v = 0;
    int rb = 0, gap = 0, cur = 0, nbeats;
    logic [31:0] held = '0;
    logic [2:0]  vprev = '0;
    nbeats = cached_i ? 8 : 1;
    first_rd = -1; first_wr = -1; n_fill = 0; n_ref = 0; ref_cyc = -1; idle_cyc = -1;
    n_uc = 0; n_wbeat = 0; done_cyc = -1; rd_addr_s = '0; wr_addr_s = '0; uc_s = '0; rd_len_s = '0;
    for (int t = 0; t < 80; t++) begin
      @(posedge clk); #1;
      miss = (t == 0); axi_raddr = ra; axi_waddr = wa; lru = lru_i;
      cached = cached_i; write_back = wb_i;
      flush = (t == flush_at); rst = (t == rst_at);
      rd_ack = nx_rd_ack; wr_ack = nx_wr_ack; wr_done = nx_wr_done;
      if (nx_wr_done) done_cyc = t;
      wr_ready = tog_rdy ? (t % 2 == 0) : 1'b1;
      vic_rdata = 32'h1111_1111 * (32'(vprev) + 1);
      rd_valid = 0; rd_last = 0; rd_data = '0;
      if (rd_on) begin
        if (gap > 0) gap--;
        else begin
          cur = rb; rd_valid = 1; rd_data = 32'hC0DE_0000 + rb;
          rd_last = (rb == nbeats - 1); rb++;
          if (rd_last) rd_on = 0;
        end
      end
      if (rst_at >= 0 && t > rst_at) bus_idle();
      #2;
      if (rst_at >= 0 && t == rst_at + 1) begin
        chk("rst_outs", outs_or(), 32'd0);
        break;
      end
      if (t > 0 && !busy) begin idle_cyc = t; break; end
      if (rd_req && first_rd < 0) begin first_rd = t; rd_addr_s = rd_addr; rd_len_s = rd_len; end
      if (wr_req && first_wr < 0) begin first_wr = t; wr_addr_s = wr_addr; end
      if (wb_i && t >= 1 && t <= 8) chk("vic_idx", 32'(vic_idx), t - 1);
      if (wb_i && t == 1) chk("vic_way", 32'(vic_way), 32'(lru_i));
      if (fill_we != 0) begin
        n_fill++;
        chk("fill_we", 32'(fill_we), lru_i ? 32'd2 : 32'd1);
        chk("fill_idx", 32'(fill_idx), cur);
        chk("fill_data", fill_data, 32'hC0DE_0000 + cur);
      end
      if (refresh) begin n_ref++; ref_cyc = t; end
      if (uc_valid) begin n_uc++; uc_s = uc_rdata; end
      if (held_v) chk("wr_hold", wr_data, held);
      held_v = wr_valid && !wr_ready; held = wr_data;
      if (wr_valid && wr_ready) begin
        chk("wr_data", wr_data, 32'h1111_1111 * (n_wbeat + 1));
        chk("wr_last", 32'(wr_last), 32'(n_wbeat == 7));
        n_wbeat++;
      end
      nx_wr_done = wr_valid && wr_ready && wr_last;
      nx_wr_ack  = wr_req && !wr_ack;
      nx_rd_ack  = rd_req && !rd_ack;
      if (rd_req && rd_ack) begin rd_on = 1; rb = 0; gap = rd_gap; end
      vprev = vic_idx;
    end
    if (rst_at < 0 && idle_cyc < 0) chk("timeout_busy", 32'(busy), 32'd0);
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no-finish exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle(); rst = 1;
    repeat (3) @(posedge clk);
    #1; rst = 0;
    chk("reset_outs", outs_or(), 32'd0);

    // clean cached miss, way 0
    run(32'h1FC0_0040, 32'h0, 1'b0, 1'b1, 1'b0, 0, 0, -1, -1);
    chk("c_rd_cyc", first_rd, 1);
    chk("c_rd_addr", rd_addr_s, 32'h1FC0_0040);
    chk("c_rd_len", 32'(rd_len_s), 7);
    chk("c_fills", n_fill, 8);
    chk("c_refresh_n", n_ref, 1);
    chk("c_refresh_cyc", ref_cyc, 11);
    chk("c_idle_cyc", idle_cyc, 13);
    chk("c_no_wr", first_wr, -1);
    chk("c_no_uc", n_uc, 0);

    // dirty miss, victim way 1, wr_ready always high
    run(32'h0000_2040, 32'h0000_1040, 1'b1, 1'b1, 1'b1, 0, 0, -1, -1);
    chk("d_wr_cyc", first_wr, 10);
    chk("d_wr_addr", wr_addr_s, 32'h0000_1040);
    chk("d_wbeats", n_wbeat, 8);
    chk("d_done_cyc", done_cyc, 20);
    chk("d_rd_cyc", first_rd, 21);
    chk("d_fills", n_fill, 8);
    chk("d_refresh_cyc", ref_cyc, 31);
    chk("d_idle_cyc", idle_cyc, 33);

    // dirty miss with wr_ready toggling 1,0,1,0
    run(32'h0000_2040, 32'h0000_1040, 1'b1, 1'b1, 1'b1, 1, 0, -1, -1);
    chk("t_wbeats", n_wbeat, 8);
    chk("t_done_cyc", done_cyc, 27);
    chk("t_rd_cyc", first_rd, 28);
    chk("t_idle_cyc", idle_cyc, 40);

    // uncached single-word read
    run(32'hBFD0_F000, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, -1, -1);
    chk("u_rd_addr", rd_addr_s, 32'hBFD0_F000);
    chk("u_rd_len", 32'(rd_len_s), 0);
    chk("u_uc_n", n_uc, 1);
    chk("u_uc_data", uc_s, 32'hC0DE_0000);
    chk("u_no_fill", n_fill, 0);
    chk("u_no_refresh", n_ref, 0);
    chk("u_idle_cyc", idle_cyc, 5);

    // flush while the uncached beat is still outstanding
    run(32'hBFD0_F004, 32'h0, 1'b0, 1'b0, 1'b0, 0, 2, 4, -1);
    chk("f_uc_n", n_uc, 0);
    chk("f_idle_cyc", idle_cyc, 7);

    // reset in WB_DATA, then a clean miss on way 1
    run(32'h0000_2040, 32'h0000_1040, 1'b1, 1'b1, 1'b1, 0, 0, -1, 13);
    run(32'h1FC0_0080, 32'h0, 1'b1, 1'b1, 1'b0, 0, 0, -1, -1);
    chk("r_rd_addr", rd_addr_s, 32'h1FC0_0080);
    chk("r_fills", n_fill, 8);
    chk("r_refresh_cyc", ref_cyc, 11);
    chk("r_idle_cyc", idle_cyc, 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
